// File: rtl/usb_pkg.sv
// Shared USB line-level types for the DP/DM receive path: line codes, the SYNC
// pattern as seen on the wire, and receiver FSM states.
package usb_pkg;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        K   = 2'b01,
        J   = 2'b10,
        SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC      = 3'd1,
        PACKET    = 3'd2,
        EOP_1     = 3'd3,
        EOP_2     = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int unsigned SYNC_LEN = 8;

    // KJKJKJKK in transmission order, index 0 first on the wire.
    localparam line_t SYNC_LINE [SYNC_LEN] = '{K, J, K, J, K, J, K, K};

    function automatic logic is_busy(input rx_state_t s);
        return s inside {SYNC, PACKET, EOP_1, EOP_2};
    endfunction

endpackage

// File: rtl/dpdm_sync_hunt.sv
// SYNC pattern tracker: compares the registered line sample against the expected
// SYNC symbol while the receiver is hunting, and reports match/abort/restart.
module dpdm_sync_hunt
    import usb_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    input  logic  enable,
    input  logic  hunting,
    input  line_t line_q,
    output logic  match,
    output logic  abort,
    output logic  restart
);

    logic [2:0] idx;
    logic       hit;

    assign hit = (line_q == SYNC_LINE[idx]);

    // A mismatching K can itself be the first SYNC symbol, so it restarts the hunt.
    always_comb begin
        match   = hunting && hit && (idx == 3'd7);
        abort   = hunting && !hit && (line_q != K);
        restart = hunting && !hit && (line_q == K);
    end

    // idx is the position of the next expected symbol; entry from IDLE has
    // already consumed the leading K, so the resting value is 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx <= 3'd1;
        end else if (enable && hunting && hit && (idx != 3'd7)) begin
            idx <= idx + 3'd1;
        end else begin
            idx <= 3'd1;
        end
    end

endmodule

// File: rtl/dpdm_decode.sv
// USB DP/DM line receiver: hunts for SYNC, forwards post-SYNC J/K line bits to the
// NRZI decoder, detects EOP and flags SE1, bad-EOP, empty and overlong packets.
module dpdm_decode
    import usb_pkg::*;
#(
    parameter int unsigned MAX_BITS    = 1024,
    parameter int unsigned IDLE_CYCLES = 2
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        DP,
    input  logic        DM,
    input  logic        rx_enable,
    output logic        out_bit,
    output logic        out_valid,
    output logic        pkt_start,
    output logic        rx_done,
    output logic        rx_error,
    output logic        rx_busy,
    output logic [15:0] bit_count
);

    localparam int unsigned IW        = $clog2(IDLE_CYCLES + 1);
    localparam logic [15:0] MAX_COUNT = 16'(MAX_BITS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

    generate
        if (MAX_BITS == 0 || MAX_BITS > 65535) begin : g_bad_max_bits
            $error("dpdm_decode: MAX_BITS must be in 1..65535");
        end
        if (IDLE_CYCLES == 0) begin : g_bad_idle_cycles
            $error("dpdm_decode: IDLE_CYCLES must be at least 1");
        end
    endgenerate

    line_t         line_q;
    rx_state_t     state;
    rx_state_t     state_d;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_d;
    logic [15:0]   bit_count_d;
    logic          bit_d;
    logic          valid_d;
    logic          start_d;
    logic          done_d;
    logic          error_d;
    logic          sync_match;
    logic          sync_abort;
    logic          sync_restart;

    dpdm_sync_hunt u_sync_hunt (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (rx_enable),
        .hunting (state == SYNC),
        .line_q  (line_q),
        .match   (sync_match),
        .abort   (sync_abort),
        .restart (sync_restart)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= J;
        end else begin
            line_q <= line_t'({DP, DM});
        end
    end

    always_comb begin
        state_d     = state;
        idle_d      = idle_cnt;
        bit_count_d = bit_count;
        bit_d       = 1'b0;
        valid_d     = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;

        if (!rx_enable) begin
            state_d = IDLE;
            idle_d  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_q == K) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (sync_match) begin
                        state_d     = PACKET;
                        start_d     = 1'b1;
                        bit_count_d = '0;
                    end else if (sync_abort) begin
                        state_d = IDLE;
                    end else if (sync_restart) begin
                        state_d = SYNC;
                    end
                end
                PACKET: begin
                    case (line_q)
                        J, K: begin
                            // The bit that would push the count past the limit is dropped.
                            if (bit_count == MAX_COUNT) begin
                                error_d = 1'b1;
                            end else begin
                                valid_d     = 1'b1;
                                bit_d       = (line_q == J);
                                bit_count_d = bit_count + 16'd1;
                            end
                        end
                        SE0: begin
                            if (bit_count == '0) begin
                                error_d = 1'b1;
                            end else begin
                                state_d = EOP_1;
                            end
                        end
                        default: error_d = 1'b1;
                    endcase
                end
                EOP_1: begin
                    if (line_q == SE0) begin
                        state_d = EOP_2;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                EOP_2: begin
                    if (line_q == J) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (line_q != J) begin
                        idle_d = '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state_d = IDLE;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_cnt + IW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (error_d) begin
                state_d = WAIT_IDLE;
                idle_d  = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idle_cnt  <= '0;
            bit_count <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            pkt_start <= 1'b0;
            rx_done   <= 1'b0;
            rx_error  <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_d;
            idle_cnt  <= idle_d;
            bit_count <= bit_count_d;
            out_bit   <= bit_d;
            out_valid <= valid_d;
            pkt_start <= start_d;
            rx_done   <= done_d;
            rx_error  <= error_d;
            rx_busy   <= is_busy(state_d);
        end
    end

endmodule
